// File: rtl/ysyx_25040105_imem_pkg.sv
// Shared definitions for the instruction-memory responder and the fetch unit.
//   imem_state_e : responder FSM states
//   RESET_PC     : first fetch address after reset; also the memory base
//   INST_W       : instruction word width
package ysyx_25040105_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          INST_W   = 32;

endpackage

// File: rtl/ysyx_25040105_imem_array.sv
// Word array with one synchronous read port and one write port.
//   clk, rst         : clock, async active-high reset (read register only)
//   rd_en, rd_idx    : read strobe and word index; data appears after the edge
//   rd_data          : registered read data, held between reads
//   wr_en, wr_idx,
//   wr_data          : write strobe, word index and data
// A read and a write to the same word on one edge return the old word,
// since both sample the array before the non-blocking update lands.
module ysyx_25040105_imem_array
  import ysyx_25040105_imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [INST_W-1:0] wr_data
);

  // Storage is intentionally not reset so it can map onto block RAM.
  logic [INST_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ysyx_25040105_imem.sv
// Instruction-memory responder: one outstanding fetch, fixed latency,
// response held until consumed, flush drops the in-flight fetch.
//   clk, rst                       : clock, async active-high reset
//   req_valid/req_ready/req_addr   : fetch request handshake (byte PC)
//   flush                          : discard in-flight fetch
//   resp_valid/resp_ready          : response handshake
//   resp_inst, resp_err            : instruction word, bad-address flag
//   wr_en/wr_addr/wr_data          : program image write port
module ysyx_25040105_imem
  import ysyx_25040105_imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = RESET_PC,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [INST_W-1:0] resp_inst,
  output logic              resp_err,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [INST_W-1:0] wr_data
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  imem_state_e       state;
  logic [3:0]        cnt;
  logic              err_q;
  logic [INST_W-1:0] rd_data;

  // Offsets from the base: an address below the base wraps to a huge
  // unsigned offset, so one compare covers both range limits.
  logic [31:0] req_off, wr_off;
  logic        req_bad, wr_ok, accept;

  assign req_off = req_addr - BASE_ADDR;
  assign wr_off  = wr_addr  - BASE_ADDR;
  assign req_bad = (req_addr[1:0] != 2'b00) || (req_off >= SPAN);
  assign wr_ok   = (wr_addr[1:0]  == 2'b00) && (wr_off  <  SPAN);
  assign accept  = (state == IDLE) && req_valid && !flush;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  // Bad addresses still read some wrapped word; the flag masks it to 0.
  assign resp_inst  = err_q ? '0 : rd_data;

  ysyx_25040105_imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (accept),
    .rd_idx (req_off[AW+1:2]),
    .rd_data(rd_data),
    .wr_en  (wr_en && wr_ok),
    .wr_idx (wr_off[AW+1:2]),
    .wr_data(wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          err_q <= req_bad;
          cnt   <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: if (flush) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (flush || resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_imem.sv
module tb_ysyx_25040105_imem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, flush = 0, resp_ready = 1, wr_en = 0;
  logic [31:0] req_addr = BASE, wr_addr = BASE, wr_data = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst;
  logic        r1_ready, v1, e1;
  logic [31:0] i1;

  int n_chk = 0, n_pass = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ysyx_25040105_imem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  ysyx_25040105_imem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(v1),
    .resp_ready(resp_ready), .resp_inst(i1), .resp_err(e1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference address rules: aligned and inside [BASE, BASE+DEPTH*4).
  function automatic bit bad(input logic [31:0] a);
    longint unsigned ua = a;
    return (a % 4 != 0) || (ua < BASE) || (ua >= longint'(BASE) + DEPTH * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return bad(a) ? 32'h0 : ref_mem[widx(a)];
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    if (!bad(a)) ref_mem[widx(a)] = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
    mem_wr(a, d);
  endtask

  // One complete fetch: optional write on the acceptance edge, optional
  // random writes to the same word while the fetch is in flight.
  task automatic fetch(input string tag, input logic [31:0] a, input bit cw,
                       input logic [31:0] wa, input logic [31:0] wd, input bit noisy);
    logic [31:0] e_inst;
    bit          e_err;
    int          lat;
    e_err  = bad(a);
    e_inst = exp_word(a);
    chk({tag, ".rdy_pre"}, 32'(req_ready), 1);
    req_valid = 1; req_addr = a; resp_ready = 1;
    wr_en = cw; wr_addr = wa; wr_data = wd;
    step();
    req_valid = 0; wr_en = 0;
    if (cw) mem_wr(wa, wd);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (noisy) begin wr_en = 1'($urandom_range(0, 1)); wr_addr = a; wr_data = $urandom; end
      step();
      if (wr_en) mem_wr(wr_addr, wr_data);
      wr_en = 0;
      lat++;
    end
    chk({tag, ".lat"},  32'(lat), 32'(LAT));
    chk({tag, ".inst"}, resp_inst, e_inst);
    chk({tag, ".err"},  32'(resp_err), 32'(e_err));
    step();
    chk({tag, ".rdy_post"}, 32'(req_ready), 1);
    chk({tag, ".vld_post"}, 32'(resp_valid), 0);
  endtask

  initial begin
    logic [31:0] a, e;
    int acc, rsp, w;

    // reset state
    step(); step();
    chk("rst.req_ready", 32'(req_ready), 1);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.resp_inst", resp_inst, 0);
    chk("rst.resp_err", 32'(resp_err), 0);
    rst = 0;
    step();

    // preload image
    wr(BASE, 32'h0000_0413);
    wr(BASE + 4, 32'h0010_0093);
    for (int i = 2; i < DEPTH; i++) wr(BASE + 32'(i * 4), $urandom);

    fetch("basic0", BASE, 0, 0, 0, 0);
    chk("basic0.word", ref_mem[0], 32'h0000_0413);
    fetch("basic1", BASE + 4, 0, 0, 0, 0);

    // backpressure
    e = exp_word(BASE + 8);
    req_valid = 1; req_addr = BASE + 8; resp_ready = 0;
    step();
    req_valid = 0;
    w = 0;
    while (!resp_valid && w < 40) begin step(); w++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(resp_valid), 1);
      chk("bp.inst", resp_inst, e);
      chk("bp.ready", 32'(req_ready), 0);
      step();
    end
    resp_ready = 1;
    step();
    chk("bp.rel_ready", 32'(req_ready), 1);
    chk("bp.rel_valid", 32'(resp_valid), 0);

    // bad addresses
    fetch("err_mis", BASE + 2, 0, 0, 0, 0);
    fetch("err_low", 32'h7FFF_FFFC, 0, 0, 0, 0);
    fetch("err_high", BASE + DEPTH * 4, 0, 0, 0, 0);

    // flush in WAIT
    req_valid = 1; req_addr = BASE;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("fl_wait.ready", 32'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      chk("fl_wait.novalid", 32'(resp_valid), 0);
      step();
    end

    // flush in RESP
    req_valid = 1; req_addr = BASE + 4; resp_ready = 0;
    step();
    req_valid = 0;
    w = 0;
    while (!resp_valid && w < 40) begin step(); w++; end
    chk("fl_resp.valid_before", 32'(resp_valid), 1);
    flush = 1;
    step();
    flush = 0; resp_ready = 1;
    chk("fl_resp.valid", 32'(resp_valid), 0);
    chk("fl_resp.ready", 32'(req_ready), 1);

    // flush with request in IDLE blocks acceptance
    flush = 1; req_valid = 1; req_addr = BASE;
    step();
    chk("fl_idle.ready", 32'(req_ready), 1);
    flush = 0; req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("fl_idle.novalid", 32'(resp_valid), 0);
      step();
    end

    // same-edge write/read collision returns the old word
    ref_mem[3] = ref_mem[3];
    fetch("coll_old", BASE + 12, 1, BASE + 12, 32'hDEAD_BEEF, 0);
    chk("coll.model", ref_mem[3], 32'hDEAD_BEEF);
    fetch("coll_new", BASE + 12, 0, 0, 0, 0);

    // randomized fetches with concurrent and in-flight writes
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        1:       a = BASE - 32'($urandom_range(1, 16));
        2:       a = BASE + DEPTH * 4 + 32'($urandom_range(0, 16));
        default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      if ($urandom_range(0, 1) == 1)
        fetch("rnd", a, 1, (($urandom_range(0, 1) == 1) ? a : BASE + 32'($urandom_range(0, DEPTH - 1) * 4)),
              $urandom, 1);
      else
        fetch("rnd", a, 0, 0, 0, 1);
    end

    // asynchronous reset mid-WAIT, away from the clock edge
    req_valid = 1; req_addr = BASE;
    step();
    req_valid = 0;
    #3 rst = 1;
    #1;
    chk("arst.valid", 32'(resp_valid), 0);
    chk("arst.ready", 32'(req_ready), 1);
    chk("arst.inst", resp_inst, 0);
    #2 rst = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("arst.novalid", 32'(resp_valid), 0);
      step();
    end

    // LATENCY=1 instance: back-to-back fetches every two cycles
    a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
    e = exp_word(a);
    req_valid = 1; req_addr = a; resp_ready = 1;
    acc = 0; rsp = 0;
    for (int i = 0; i < 12; i++) begin
      if (r1_ready) acc++;
      if (v1) begin rsp++; chk("l1.inst", i1, e); end
      step();
    end
    chk("l1.accepts", 32'(acc), 6);
    chk("l1.resps", 32'(rsp), 6);
    req_valid = 0;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25040105_imem.md
# ysyx_25040105_imem

Instruction-memory responder. It sits on the fetch side opposite the PC/fetch unit: it accepts one fetch address per valid/ready handshake and returns the 32-bit instruction word after a fixed, parameterised latency. The response is held until it is consumed. A flush input discards any in-flight fetch on a taken jump. A write port preloads or patches the program image.

## Interface
- DEPTH_WORDS, 1024 — memory size in 32-bit words; power of two, ≥ 4
- BASE_ADDR, 32'h8000_0000 — byte address of word 0; aligned to DEPTH_WORDS*4
- LATENCY, 2 — cycles from request acceptance to first resp_valid; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  fetch byte address (PC)
- flush  in  1  discard in-flight fetch (jump redirect)
- resp_valid  out  1  instruction available
- resp_ready  in  1  consumer takes response
- resp_inst  out  32  instruction word
- resp_err  out  1  address misaligned or outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)
- wr_en  in  1  memory write strobe
- wr_addr  in  32  write byte address; same decode as req_addr; illegal addresses are ignored
- wr_data  in  32  write data

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, latency counter=0. The memory array is not reset.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && !flush.
  - On accept, latch `err = (req_addr[1:0]!=0) || out-of-range`.
  - On accept, read mem[index] into the data register, or 0 if err. Index = (req_addr-BASE_ADDR)>>2.
  - Load counter = LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - Go to RESP on the cycle the counter is 1.
- RESP:
  - resp_valid=1. resp_inst and resp_err are driven from the latched registers and are stable while resp_valid && !resp_ready.
  - On resp_ready, go to IDLE.
- flush:
  - In WAIT or RESP, go to IDLE next edge. No response is delivered and resp_valid drops.
  - In IDLE, flush blocks acceptance that cycle. req_ready stays 1, but no handshake occurs.
- Only one request is outstanding at a time. No new acceptance is allowed while in WAIT or RESP.
- Write port:
  - Writes occur every edge with wr_en, independent of FSM state.
  - Write and accepted read to the same word on the same edge: the read returns the OLD data (read-before-write).
  - Writes after acceptance do not alter a latched response.
- Reset asserted mid-operation: immediate return to IDLE. All outputs go to their reset values. The pending response is lost.

## Timing
- Request accepted at edge E0. resp_valid rises after edge E0+LATENCY−1, i.e. it is visible in cycle LATENCY after acceptance. With LATENCY=1, it is visible the cycle after acceptance.
- Response consumed at edge E1. req_ready is 1 in the following cycle.
- Peak throughput: one fetch per LATENCY+1 cycles.
- req_ready is a pure function of state (IDLE). It has no combinational path from req_valid, resp_ready or flush.
- resp_valid, resp_inst and resp_err are registered-state outputs with no combinational input paths.

## Structure
- Shared package holds:
  - FSM state enum (IDLE/WAIT/RESP)
  - RESET_PC constant 32'h8000_0000 (common with the fetch unit)
  - instruction width constant 32
- Sub-module ysyx_25040105_imem_array: single-port-read / single-port-write word array with synchronous read. It owns the read-before-write behaviour.
- The top level holds the FSM, counter, address decode and response registers.

## Test plan
- Reset, then preload mem[0]=32'h0000_0413 and mem[1]=32'h0010_0093 via the write port. Request 32'h8000_0000 with LATENCY=2 and resp_ready=1 → resp_valid in cycle 2 after acceptance, resp_inst=32'h0000_0413, resp_err=0. Next request 32'h8000_0004 → 32'h0010_0093.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and resp_inst stable, req_ready=0 throughout. Release → IDLE next cycle.
- Errors: request 32'h8000_0002 → resp_err=1, resp_inst=0. Request 32'h7FFF_FFFC and BASE_ADDR+DEPTH_WORDS*4 → resp_err=1.
- Flush: assert flush in WAIT → no resp_valid ever, req_ready=1 next cycle. Flush while in RESP → resp_valid drops next cycle. Flush and req_valid in IDLE → no acceptance.
- Collision: write mem[3]=32'hDEAD_BEEF on the same edge a read of 32'h8000_000C is accepted → old value returned. The next read of that word returns 32'hDEAD_BEEF.
- Asynchronous reset pulse mid-WAIT, not clock-aligned → resp_valid=0 and req_ready=1 immediately. LATENCY=1 sweep gives back-to-back fetches every 2 cycles.
